// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and frame defaults.
// Used by the transmitter, receiver and baud tick generator.
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_SB_TICK    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_t;

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// TX FIFO port: first-word-fall-through head word,
// empty flag and one-cycle pop strobe.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] i_fifo_data;
  logic                  i_fifo_empty;
  logic                  o_fifo_read;

  modport master (
    output i_fifo_data,
    output i_fifo_empty,
    input  o_fifo_read
  );

  modport slave (
    input  i_fifo_data,
    input  i_fifo_empty,
    output o_fifo_read
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pops the TX FIFO when idle and sends
// start, LSB-first data and stop on the oversampling tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SB_TICK    = DEF_SB_TICK
) (
  input  logic     i_clock,
  input  logic     i_reset,
  input  logic     i_tick,
  uart_tx_if.slave fifo,
  output logic     o_tx,
  output logic     o_busy,
  output logic     o_done_tick
);

  localparam int TMAX = max2(OVERSAMPLE, SB_TICK);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;

  // Frame sequencer; every output is a register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state            <= IDLE;
      tick_cnt         <= '0;
      bit_cnt          <= '0;
      shift            <= '0;
      o_tx             <= 1'b1;
      o_busy           <= 1'b0;
      o_done_tick      <= 1'b0;
      fifo.o_fifo_read <= 1'b0;
    end else begin
      fifo.o_fifo_read <= 1'b0;
      o_done_tick      <= 1'b0;
      unique case (state)
        IDLE: begin
          o_tx <= 1'b1;
          if (!fifo.i_fifo_empty) begin
            shift            <= fifo.i_fifo_data;
            tick_cnt         <= '0;
            bit_cnt          <= '0;
            o_tx             <= 1'b0;
            o_busy           <= 1'b1;
            fifo.o_fifo_read <= 1'b1;
            state            <= START;
          end
        end
        START: begin
          if (i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              o_tx     <= shift[0];
              state    <= DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (i_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              if (bit_cnt == BIT_LAST) begin
                o_tx  <= 1'b1;
                state <= STOP;
              end else begin
                shift   <= {1'b0, shift[DATA_WIDTH-1:1]};
                o_tx    <= shift[1];
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (i_tick) begin
            if (tick_cnt == SB_LAST) begin
              tick_cnt    <= '0;
              o_done_tick <= 1'b1;
              o_busy      <= 1'b0;
              state       <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: FIFO model, tick every 4 clocks,
// frames checked tick by tick against an expected level list.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic [1:0] ph = '0;
  logic emp = 1'b1;
  logic [DW-1:0] dat = '0;
  logic sel = 1'b0;
  logic noisy = 1'b0;
  logic [7:0] q[$];

  int ncheck = 0;
  int npass = 0;
  int nfail = 0;
  int pops16 = 0;
  int pops32 = 0;
  int exp16 = 0;
  int exp32 = 0;

  logic tx16, busy16, done16;
  logic tx32, busy32, done32;

  uart_tx_if #(.DATA_WIDTH(DW)) f16 ();
  uart_tx_if #(.DATA_WIDTH(DW)) f32 ();

  assign f16.i_fifo_data  = dat;
  assign f32.i_fifo_data  = dat;
  assign f16.i_fifo_empty = sel ? 1'b1 : emp;
  assign f32.i_fifo_empty = sel ? emp : 1'b1;

  uart_tx #(
    .DATA_WIDTH(DW),
    .OVERSAMPLE(OS),
    .SB_TICK(16)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_tick(tick),
    .fifo(f16.slave),
    .o_tx(tx16),
    .o_busy(busy16),
    .o_done_tick(done16)
  );

  uart_tx #(
    .DATA_WIDTH(DW),
    .OVERSAMPLE(OS),
    .SB_TICK(32)
  ) dut32 (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_tick(tick),
    .fifo(f32.slave),
    .o_tx(tx32),
    .o_busy(busy32),
    .o_done_tick(done32)
  );

  wire tx   = sel ? tx32 : tx16;
  wire busy = sel ? busy32 : busy16;
  wire done = sel ? done32 : done16;
  wire rd   = sel ? f32.o_fifo_read : f16.o_fifo_read;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ph   <= ph + 2'd1;
    tick <= (ph == 2'd3);
  end

  always @(posedge clk) begin
    if (f16.o_fifo_read) pops16 <= pops16 + 1;
    if (f32.o_fifo_read) pops32 <= pops32 + 1;
    if (rd && q.size() > 0) void'(q.pop_front());
  end

  always @(negedge clk) begin
    if (noisy) begin
      emp = 1'($urandom_range(0, 1));
      dat = 8'($urandom);
    end else begin
      emp = (q.size() == 0);
      dat = (q.size() > 0) ? q[0] : '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncheck++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    int g = 0;
    while (tick !== 1'b1 && g < 16) begin
      @(negedge clk);
      g++;
    end
    if (tick !== 1'b1) chk("tick_timeout", 32'(tick), 1);
  endtask

  task automatic walk(input string tag, input logic lvl, input int n);
    for (int k = 0; k < n; k++) begin
      wait_tick();
      chk(tag, 32'(tx), 32'(lvl));
      @(negedge clk);
    end
  endtask

  task automatic wait_pop();
    int g = 0;
    while (rd !== 1'b1 && g < 400) begin
      @(negedge clk);
      g++;
    end
    chk("pop_seen", 32'(rd), 1);
    chk("start_tx", 32'(tx), 0);
    chk("start_busy", 32'(busy), 1);
  endtask

  // Expected line: start(0) x OS, data LSB first x OS, stop(1) x SB.
  task automatic frame(input logic [7:0] b, input bit mess);
    int sbt;
    sbt = sel ? 32 : 16;
    wait_pop();
    noisy = mess;
    walk("start_bit", 1'b0, OS);
    for (int i = 0; i < DW; i++) walk("data_bit", b[i], OS);
    noisy = 1'b0;
    walk("stop_bit", 1'b1, sbt);
    chk("done_tick", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] bl[$];
    int bad;

    q.push_back(8'h55);
    repeat (10) @(negedge clk);
    chk("rst_tx", 32'(tx16), 1);
    chk("rst_busy", 32'(busy16), 0);
    chk("rst_done", 32'(done16), 0);
    chk("rst_read", 32'(f16.o_fifo_read), 0);
    chk("rst_pops", 32'(pops16), 0);
    chk("rst_tx32", 32'(tx32), 1);
    rst_n = 1'b1;

    frame(8'h55, 1'b0);
    exp16++;
    @(negedge clk);
    chk("single_pops", 32'(pops16), 32'(exp16));
    chk("single_done_once", 32'(done16), 0);

    q.push_back(8'hA3);
    q.push_back(8'h0F);
    frame(8'hA3, 1'b0);
    @(negedge clk);
    chk("b2b_gap_rd", 32'(rd), 1);
    chk("b2b_gap_tx", 32'(tx), 0);
    frame(8'h0F, 1'b0);
    exp16 += 2;
    chk("b2b_pops", 32'(pops16), 32'(exp16));

    for (int r = 0; r < 4; r++) bl.push_back(8'($urandom));
    foreach (bl[i]) q.push_back(bl[i]);
    foreach (bl[i]) frame(bl[i], 1'b0);
    exp16 += 4;
    chk("rand_pops", 32'(pops16), 32'(exp16));

    repeat (20) @(negedge clk);
    b = 8'($urandom);
    q.push_back(b);
    frame(b, 1'b1);
    exp16++;
    repeat (40) @(negedge clk);
    chk("noisy_pops", 32'(pops16), 32'(exp16));
    chk("noisy_idle", 32'(tx16), 1);

    sel = 1'b1;
    b = 8'($urandom);
    q.push_back(8'hFF);
    q.push_back(b);
    frame(8'hFF, 1'b0);
    @(negedge clk);
    chk("sb32_gap_rd", 32'(rd), 1);
    frame(b, 1'b0);
    exp32 += 2;
    chk("sb32_pops", 32'(pops32), 32'(exp32));
    chk("sb32_other_pops", 32'(pops16), 32'(exp16));
    sel = 1'b0;

    repeat (10) @(negedge clk);
    q.push_back(8'h81);
    wait_pop();
    exp16++;
    walk("rst_start", 1'b0, OS);
    walk("rst_b0", 1'b1, OS);
    walk("rst_b1", 1'b0, OS);
    walk("rst_b2", 1'b0, OS);
    walk("rst_b3", 1'b0, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx16), 1);
    chk("mid_rst_busy", 32'(busy16), 0);
    chk("mid_rst_done", 32'(done16), 0);
    chk("mid_rst_read", 32'(f16.o_fifo_read), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx16 !== 1'b1 || busy16 !== 1'b0) bad++;
    end
    chk("idle_after_rst", 32'(bad), 0);
    chk("rst_pops_kept", 32'(pops16), 32'(exp16));

    b = 8'($urandom);
    q.push_back(b);
    frame(b, 1'b0);
    exp16++;
    @(negedge clk);
    chk("post_rst_pops", 32'(pops16), 32'(exp16));

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
